uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver; the receive-side counterpart of the team's 8N1 UART transmitter (start bit, 8 data bits LSB first, 1 stop bit).
//  - Converts the asynchronous serial line rx_in into a parallel byte plus a one-cycle valid strobe.
//  - Sits between the board pin and the byte consumer (loopback logic, command parser).
// PARAMETERS
//  - CLK_FREQ      50_000_000  sys_clk frequency, Hz
//  - BAUD          9600        line rate, bit/s
//  - BAUD_CNT_MAX  CLK_FREQ/BAUD (5208)  clocks per bit, derived, not to be overridden
//  - BIT_MID       BAUD_CNT_MAX/2 (2604)  sample point within a bit, derived
// PORTS
//  - sys_clk    in   1  system clock, all logic on rising edge
//  - sys_rst    in   1  asynchronous, active-high reset
//  - rx_in      in   1  serial line, asynchronous to sys_clk, idle high
//  - rx_data    out  8  last good byte; held until the next good byte
//  - rx_valid   out  1  1-cycle pulse: rx_data updated this cycle
//  - frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//  - rx_busy    out  1  high while the FSM is outside IDLE
// BEHAVIOUR
//  - Reset: rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0, FSM=IDLE, sync FFs=1, counters=0.
//  - rx_in passes through a 2-FF synchronizer plus one delay FF for falling-edge detection.
//    No logic touches raw rx_in.
//  - baud_cnt runs 0..BAUD_CNT_MAX-1 and wraps while not in IDLE. It is held at 0 in IDLE.
//  - Each state samples the synced line at baud_cnt==BIT_MID-1.
//  - FSM states and transitions:
//    - IDLE:  synced falling edge -> START; baud_cnt=0, bit_cnt=0.
//    - START: sample 1 -> IDLE (glitch/false start, no strobe). Sample 0 -> continue. Wrap -> DATA.
//    - DATA:  each sample shifts in LSB first (shift right, new bit into [7]), bit_cnt++.
//             Wrap after bit_cnt==8 -> STOP.
//    - STOP:  sample 1 -> rx_data<=shift reg, rx_valid=1 next cycle, -> IDLE.
//             Sample 0 -> frame_err=1 next cycle, rx_data unchanged, -> IDLE.
//  - The FSM returns to IDLE at mid-stop, so a start edge arriving within the last half stop bit is caught.
//    This tolerates a receiver clock up to about 3% slower than the transmitter.
//  - A frame_err caused by a break (line held low) does not re-trigger: IDLE needs a high->low edge.
//  - Latency: rx_valid asserts 9*BAUD_CNT_MAX+BIT_MID+3 cycles (+-1) after the pin start edge.
//  - rx_valid and frame_err are mutually exclusive and never assert twice per frame.
//  - rx_busy = (FSM != IDLE), registered alongside the state.
//  - Reset mid-frame: immediate return to reset values. A partial byte is never presented.
//  - Widths: baud_cnt $clog2(BAUD_CNT_MAX) bits, bit_cnt 4 bits. No arithmetic wraps beyond these.
// STRUCTURE
//  - Shared package uart_pkg:
//    - state encoding localparams IDLE/START/DATA/STOP (2 bits).
//    - DATA_BITS=8.
//    - a baud-count helper function, reused by the transmitter.
//  - Sub-module uart_rx_sync: 2-FF synchronizer with a registered falling-edge pulse output, reset to 1.
//  - Top level: FSM, baud_cnt, bit_cnt, shift register, output registers.
// TESTING
//  - Bench overrides CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_CNT_MAX=10 and BIT_MID=5.
//  - Directed scenarios:
//    1. Send 0x55, then 0xA3, idle between them -> two rx_valid pulses; rx_data=0x55, then 0xA3; frame_err never asserts.
//    2. Back-to-back 0x00 then 0xFF, no idle gap -> both bytes received; rx_busy drops for <=6 cycles between frames.
//    3. rx_in low for 3 cycles, then high -> no rx_valid, no frame_err; FSM back in IDLE by cycle BIT_MID+3.
//    4. Send 0x3C with stop bit forced low -> frame_err pulses once; no rx_valid; rx_data keeps its previous value.
//    5. Assert sys_rst during data bit 4 of 0x81, release, then send 0x7E -> outputs are at reset values during reset; only 0x7E is reported.
//    6. Send 0x96 at BAUD +3% and -3% -> rx_data=0x96, rx_valid pulses once each time.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the 8N1 UART receiver and transmitter: state encoding,
// frame width and the clocks-per-bit helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Whole sys_clk cycles per bit; the fractional remainder is absorbed by
  // re-aligning on every start edge.
  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, plus a delay flop
// whose comparison with the synchronized line yields a one-cycle falling-edge pulse.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All three flops reset to the idle-high line level so reset release never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit, 8 data bits LSB first, 1 stop bit, each bit
// sampled at its midpoint. Emits the byte with a one-cycle strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int BIT_MID      = BAUD_CNT_MAX / 2;
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(BIT_MID - 1);
  localparam logic [3:0]       BITS_LAST  = 4'(DATA_BITS);

  logic              line;
  logic              line_fall;
  logic              sample;
  logic              wrap;

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q;

  uart_rx_sync u_sync (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .rx_i   (rx_in),
    .line_o (line),
    .fall_o (line_fall)
  );

  assign sample = (baud_cnt_q == CNT_SAMPLE);
  assign wrap   = (baud_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != IDLE) begin
      baud_cnt_d = wrap ? '0 : baud_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (line_fall) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (sample && line) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d   = {line, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (wrap && bit_cnt_q == BITS_LAST) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a start edge in the second half of the stop bit is still seen.
        if (sample) begin
          if (line) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d    = IDLE;
          baud_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  // rx_valid is a strobe with no back-pressure: rx_data is new in exactly the
  // cycle rx_valid is high and stays put until the next good byte.
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = busy_q;

endmodule
